// File: rtl/hex_display_scanner_pkg.sv
// Shared definitions for the hex display scanner: segment bus layout, glyph table and slot FSM states.
// Segment bus is active-low, bit 6 = g down to bit 0 = a.
package hex_display_scanner_pkg;

    localparam int SEG_W = 7;
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t GLYPH_0    = 7'b1000000;
    localparam seg_t GLYPH_1    = 7'b1111001;
    localparam seg_t GLYPH_2    = 7'b0100100;
    localparam seg_t GLYPH_3    = 7'b0110000;
    localparam seg_t GLYPH_4    = 7'b0011001;
    localparam seg_t GLYPH_5    = 7'b0010010;
    localparam seg_t GLYPH_6    = 7'b0000010;
    localparam seg_t GLYPH_7    = 7'b1111000;
    localparam seg_t GLYPH_8    = 7'b0000000;
    localparam seg_t GLYPH_9    = 7'b0010000;
    localparam seg_t GLYPH_A    = 7'b0001000;
    localparam seg_t GLYPH_B    = 7'b0000011;
    localparam seg_t GLYPH_C    = 7'b1000110;
    localparam seg_t GLYPH_D    = 7'b0100001;
    localparam seg_t GLYPH_E    = 7'b0000110;
    localparam seg_t GLYPH_F    = 7'b0001110;
    localparam seg_t GLYPH_DARK = 7'b1111111;

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    function automatic seg_t hex_glyph(input logic [3:0] nib);
        seg_t g;
        g = GLYPH_DARK;
        case (nib)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            4'hF: g = GLYPH_F;
            default: g = GLYPH_DARK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_display_scanner_scan_prescaler.sv
// Slot timer: counts 0..CLK_DIV-1 while enabled, flags the last cycle of a slot (tick) and the
// last guard cycle (drive_start). Combinational flags from a registered count; holds when disabled.
module hex_display_scanner_scan_prescaler #(
    parameter int CLK_DIV = 50000,
    parameter int GUARD   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick,
    output logic drive_start
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick        = enable && (cnt == CNT_W'(CLK_DIV - 1));
    assign drive_start = enable && (cnt == CNT_W'(GUARD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver; an/seg/frame registered (1 cycle after slot state).
// New values are held in a one-deep pending slot and committed only at frame boundaries; load_ready stays low while it is full.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [SEG_W-1:0]        seg,
    output logic                    frame
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic                  tick;
    logic                  drive_start;
    logic                  boundary;
    logic                  accept;
    logic                  commit;

    logic [IDX_W-1:0]      idx;
    logic [0:0]            state;

    logic [VAL_W-1:0]      disp_value;
    logic [NUM_DIGITS-1:0] disp_mask;
    logic [VAL_W-1:0]      pend_value;
    logic [NUM_DIGITS-1:0] pend_mask;
    logic                  pend_full;

    logic [NUM_DIGITS-1:0] dark_vec;
    logic                  zero_above;
    logic [3:0]            cur_nibble;

    hex_display_scanner_scan_prescaler #(
        .CLK_DIV (CLK_DIV),
        .GUARD   (GUARD)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick        (tick),
        .drive_start (drive_start)
    );

    assign boundary   = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign load_ready = ~pend_full;
    assign accept     = load_valid && load_ready;
    // A transfer on the boundary cycle cannot commit here: pend_full is still clear.
    assign commit     = boundary && pend_full;
    assign cur_nibble = disp_value[{idx, 2'b00} +: 4];

    // Scan from the top digit down so zero_above covers nibbles i..NUM_DIGITS-1.
    always_comb begin
        zero_above = 1'b1;
        dark_vec   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above && (disp_value[4*i +: 4] == 4'h0);
            dark_vec[i] = disp_mask[i] || (lz_en && (i > 0) && zero_above);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            state <= ST_GUARD;
            frame <= 1'b0;
        end else begin
            frame <= boundary;
            if (tick) begin
                idx   <= boundary ? '0 : idx + 1'b1;
                state <= ST_GUARD;
            end else if (drive_start) begin
                state <= ST_DRIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full  <= 1'b0;
            pend_value <= '0;
            pend_mask  <= '0;
            disp_value <= '0;
            disp_mask  <= '1;
        end else begin
            if (commit) begin
                disp_value <= pend_value;
                disp_mask  <= pend_mask;
                pend_full  <= 1'b0;
            end
            if (accept) begin
                pend_value <= value;
                pend_mask  <= blank_mask;
                pend_full  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= GLYPH_DARK;
        end else if (enable && (state == ST_DRIVE) && !dark_vec[idx]) begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= hex_glyph(cur_nibble);
        end else begin
            an  <= '1;
            seg <= GLYPH_DARK;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner with a frame-position reference model (4 digits, 4-cycle slots, 1 guard cycle).
module tb_hex_display_scanner;

    localparam int N     = 4;
    localparam int CD    = 4;
    localparam int GD    = 1;
    localparam int FRAME = N * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        load_ready;
    logic        frame;
    logic [3:0]  an;
    logic [6:0]  seg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hex_display_scanner #(
        .NUM_DIGITS (N),
        .CLK_DIV    (CD),
        .GUARD      (GD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .value      (value),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .frame      (frame)
    );

    // Reference model: position in the frame is just the number of enabled cycles modulo the frame length.
    logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          ecount;
    int          m_pos;
    int          m_dig;
    logic        m_pend_full;
    logic [15:0] m_pend_val;
    logic [3:0]  m_pend_mask;
    logic [15:0] m_disp_val;
    logic [3:0]  m_disp_mask;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_frame;
    logic        exp_ready;

    function automatic logic m_dark(input int d, input logic [15:0] v, input logic [3:0] m, input logic lz);
        return m[d] || (lz && d > 0 && (v >> (4 * d)) == 16'h0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ecount      = 0;
            m_pend_full = 1'b0;
            m_disp_val  = 16'h0;
            m_disp_mask = 4'hF;
            exp_an    <= 4'hF;
            exp_seg   <= 7'h7F;
            exp_frame <= 1'b0;
            exp_ready <= 1'b1;
        end else begin
            m_pos = ecount % CD;
            m_dig = ecount / CD;
            if (enable && m_pos >= GD && !m_dark(m_dig, m_disp_val, m_disp_mask, lz_en)) begin
                exp_an  <= ~(4'b0001 << m_dig);
                exp_seg <= glyph_tab[m_disp_val[4*m_dig +: 4]];
            end else begin
                exp_an  <= 4'hF;
                exp_seg <= 7'h7F;
            end
            exp_frame <= enable && (ecount == FRAME - 1);
            if (enable && ecount == FRAME - 1 && m_pend_full) begin
                m_disp_val  = m_pend_val;
                m_disp_mask = m_pend_mask;
                m_pend_full = 1'b0;
            end else if (load_valid && !m_pend_full) begin
                m_pend_val  = value;
                m_pend_mask = blank_mask;
                m_pend_full = 1'b1;
            end
            exp_ready <= !m_pend_full;
            if (enable) ecount = (ecount + 1) % FRAME;
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] m, output bit ok);
        int n = 0;
        @(negedge clk);
        value      = v;
        blank_mask = m;
        load_valid = 1'b1;
        while (load_ready !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        ok = (load_ready === 1'b1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame !== 1'b1 && n < 3 * FRAME);
        ok = (frame === 1'b1);
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (an !== 4'hF || seg !== 7'h7F || load_ready !== 1'b1 || frame !== 1'b0) begin
            fails++;
            $display("FAIL reset_values an=%b seg=%b rdy=%b frame=%b want 1111 1111111 1 0", an, seg, load_ready, frame);
        end
        rst = 1'b0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            tests++;
            if (an !== 4'hF || seg !== 7'h7F || load_ready !== 1'b1 || frame !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold t=%0t an=%b seg=%b rdy=%b frame=%b want 1111 1111111 1 0", $time, an, seg, load_ready, frame);
            end
        end
        enable = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            tests++;
            if ({an, seg, frame, load_ready} !== {exp_an, exp_seg, exp_frame, exp_ready}) begin
                fails++;
                $display("FAIL model_reset_scan t=%0t got an=%b seg=%b fr=%b rdy=%b want an=%b seg=%b fr=%b rdy=%b",
                         $time, an, seg, frame, load_ready, exp_an, exp_seg, exp_frame, exp_ready);
            end
        end
    endtask

    task automatic test_load_1a3f;
        bit         ok;
        int         low [4];
        logic [6:0] want [4];
        want[0] = 7'b0001110;
        want[1] = 7'b0110000;
        want[2] = 7'b0001000;
        want[3] = 7'b1111001;
        for (int d = 0; d < 4; d++) low[d] = 0;
        enable = 1'b1;
        lz_en  = 1'b0;
        do_load(16'h1A3F, 4'h0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL load_1a3f_accept load_ready never rose"); end
        wait_frame(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL load_1a3f_frame no frame pulse within bound"); end
        repeat (FRAME) begin
            @(negedge clk);
            tests++;
            if ({an, seg, frame, load_ready} !== {exp_an, exp_seg, exp_frame, exp_ready}) begin
                fails++;
                $display("FAIL model_load t=%0t got an=%b seg=%b fr=%b rdy=%b want an=%b seg=%b fr=%b rdy=%b",
                         $time, an, seg, frame, load_ready, exp_an, exp_seg, exp_frame, exp_ready);
            end
            tests++;
            if ($countones(~an) > 1) begin fails++; $display("FAIL load_onehot an=%b want at most one low", an); end
            for (int d = 0; d < 4; d++) begin
                if (an[d] === 1'b0) begin
                    low[d]++;
                    tests++;
                    if (seg !== want[d]) begin
                        fails++;
                        $display("FAIL load_glyph digit%0d seg=%b want %b", d, seg, want[d]);
                    end
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (low[d] != CD - GD) begin
                fails++;
                $display("FAIL load_anode_time digit%0d low %0d cycles want %0d", d, low[d], CD - GD);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int low;
        do_load(16'h1234, 4'h0, ok);
        tests++;
        if (!ok || load_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first ok=%0b rdy=%b want accepted and rdy 0", ok, load_ready);
        end
        value      = 16'h8888;
        blank_mask = 4'h0;
        load_valid = 1'b1;
        low = 1;
        while (low < 3 * FRAME) begin
            @(negedge clk);
            tests++;
            if ({an, seg, frame, load_ready} !== {exp_an, exp_seg, exp_frame, exp_ready}) begin
                fails++;
                $display("FAIL model_b2b t=%0t got an=%b seg=%b fr=%b rdy=%b want an=%b seg=%b fr=%b rdy=%b",
                         $time, an, seg, frame, load_ready, exp_an, exp_seg, exp_frame, exp_ready);
            end
            if (load_ready === 1'b1) break;
            low++;
        end
        tests++;
        if (low > FRAME + 1) begin fails++; $display("FAIL b2b_ready_low %0d cycles want <= %0d", low, FRAME + 1); end
        @(negedge clk);
        load_valid = 1'b0;
        tests++;
        if (load_ready !== 1'b0) begin fails++; $display("FAIL b2b_second_accept rdy=%b want 0", load_ready); end
        wait_frame(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_frame no frame pulse within bound"); end
        repeat (FRAME) begin
            @(negedge clk);
            tests++;
            if ({an, seg, frame, load_ready} !== {exp_an, exp_seg, exp_frame, exp_ready}) begin
                fails++;
                $display("FAIL model_b2b_show t=%0t got an=%b seg=%b fr=%b rdy=%b want an=%b seg=%b fr=%b rdy=%b",
                         $time, an, seg, frame, load_ready, exp_an, exp_seg, exp_frame, exp_ready);
            end
            if (an !== 4'hF) begin
                tests++;
                if (seg !== 7'b0000000) begin fails++; $display("FAIL b2b_glyph an=%b seg=%b want 0000000", an, seg); end
            end
        end
    endtask

    task automatic test_leading_zero;
        bit ok;
        int lit0;
        int lit1;
        lz_en = 1'b1;
        lit0  = 0;
        lit1  = 0;
        do_load(16'h0050, 4'h0, ok);
        wait_frame(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL lz_frame no frame pulse within bound"); end
        repeat (FRAME) begin
            @(negedge clk);
            tests++;
            if ({an, seg, frame, load_ready} !== {exp_an, exp_seg, exp_frame, exp_ready}) begin
                fails++;
                $display("FAIL model_lz t=%0t got an=%b seg=%b fr=%b rdy=%b want an=%b seg=%b fr=%b rdy=%b",
                         $time, an, seg, frame, load_ready, exp_an, exp_seg, exp_frame, exp_ready);
            end
            tests++;
            if (an[3:2] !== 2'b11) begin fails++; $display("FAIL lz_upper_dark an=%b want an[3:2]=11", an); end
            if (an === 4'b1101) begin
                lit1++;
                tests++;
                if (seg !== 7'b0010010) begin fails++; $display("FAIL lz_digit1 seg=%b want 0010010", seg); end
            end
            if (an === 4'b1110) begin
                lit0++;
                tests++;
                if (seg !== 7'b1000000) begin fails++; $display("FAIL lz_digit0 seg=%b want 1000000", seg); end
            end
        end
        tests++;
        if (lit0 != CD - GD || lit1 != CD - GD) begin
            fails++;
            $display("FAIL lz_lit_cycles d0=%0d d1=%0d want %0d each", lit0, lit1, CD - GD);
        end
        lit0 = 0;
        do_load(16'h0000, 4'h0, ok);
        wait_frame(ok);
        repeat (FRAME) begin
            @(negedge clk);
            tests++;
            if (an[3:1] !== 3'b111) begin fails++; $display("FAIL lz_zero_upper an=%b want an[3:1]=111", an); end
            if (an === 4'b1110) lit0++;
        end
        tests++;
        if (lit0 != CD - GD) begin fails++; $display("FAIL lz_zero_digit0 lit %0d cycles want %0d", lit0, CD - GD); end
        lz_en = 1'b0;
    endtask

    task automatic test_enable_pause;
        bit ok;
        int n;
        int after;
        do_load(16'($urandom), 4'h0, ok);
        wait_frame(ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== 4'b1011 && n < 2 * FRAME);
        tests++;
        if (an !== 4'b1011) begin fails++; $display("FAIL pause_find_digit2 an=%b want 1011", an); end
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            tests++;
            if (an !== 4'hF || seg !== 7'h7F) begin
                fails++;
                $display("FAIL pause_dark an=%b seg=%b want 1111 1111111", an, seg);
            end
        end
        enable = 1'b1;
        after = 0;
        n     = 0;
        while (n < FRAME) begin
            @(negedge clk);
            n++;
            tests++;
            if ({an, seg, frame, load_ready} !== {exp_an, exp_seg, exp_frame, exp_ready}) begin
                fails++;
                $display("FAIL model_pause t=%0t got an=%b seg=%b fr=%b rdy=%b want an=%b seg=%b fr=%b rdy=%b",
                         $time, an, seg, frame, load_ready, exp_an, exp_seg, exp_frame, exp_ready);
            end
            if (an !== 4'b1011) break;
            after++;
        end
        tests++;
        if (after + 1 != CD - GD || an !== 4'hF) begin
            fails++;
            $display("FAIL pause_resume digit2 lit %0d cycles total then an=%b want %0d then 1111", after + 1, an, CD - GD);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            tests++;
            if ({an, seg, frame, load_ready} !== {exp_an, exp_seg, exp_frame, exp_ready}) begin
                fails++;
                $display("FAIL model_random t=%0t got an=%b seg=%b fr=%b rdy=%b want an=%b seg=%b fr=%b rdy=%b",
                         $time, an, seg, frame, load_ready, exp_an, exp_seg, exp_frame, exp_ready);
            end
            tests++;
            if ($countones(~an) > 1) begin fails++; $display("FAIL random_onehot an=%b", an); end
            rst        = ($urandom_range(0, 199) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            value      = 16'($urandom);
            blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            lz_en      = 1'($urandom);
        end
        @(negedge clk);
        rst        = 1'b0;
        enable     = 1'b1;
        load_valid = 1'b0;
        lz_en      = 1'b0;
    endtask

    task automatic test_reset_pending;
        bit ok;
        enable = 1'b1;
        wait_frame(ok);
        do_load(16'hBEEF, 4'h0, ok);
        tests++;
        if (!ok || load_ready !== 1'b0) begin fails++; $display("FAIL rstpend_accept ok=%0b rdy=%b want pending", ok, load_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (an !== 4'hF || seg !== 7'h7F || load_ready !== 1'b1 || frame !== 1'b0) begin
            fails++;
            $display("FAIL rstpend_values an=%b seg=%b rdy=%b frame=%b want 1111 1111111 1 0", an, seg, load_ready, frame);
        end
        repeat (3 * FRAME) begin
            @(negedge clk);
            tests++;
            if (an !== 4'hF || seg !== 7'h7F || load_ready !== 1'b1) begin
                fails++;
                $display("FAIL rstpend_discard an=%b seg=%b rdy=%b want dark and ready", an, seg, load_ready);
            end
            tests++;
            if ({an, seg, frame, load_ready} !== {exp_an, exp_seg, exp_frame, exp_ready}) begin
                fails++;
                $display("FAIL model_rstpend t=%0t got an=%b seg=%b fr=%b rdy=%b want an=%b seg=%b fr=%b rdy=%b",
                         $time, an, seg, frame, load_ready, exp_an, exp_seg, exp_frame, exp_ready);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_1a3f();
        test_back_to_back();
        test_leading_zero();
        test_enable_pause();
        test_random();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
